// File: rtl/conf_int_dot_seq.sv
// conf_int_dot_seq: sequencing front-end for the integer MAC datapath.
// Takes a job length and operand pairs, then returns their dot product.
module conf_int_dot_seq #(
   parameter int OP_BITWIDTH        = 16,
   parameter int DATA_PATH_BITWIDTH = 16,
   parameter int LEN_WIDTH          = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [LEN_WIDTH-1:0]          len,
   output logic                          busy,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DATA_PATH_BITWIDTH-1:0] res_data
);

   localparam int DW = DATA_PATH_BITWIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [DW-1:0]        r_acc;
   logic [DW-1:0]        r_a;
   logic [DW-1:0]        r_b;
   logic                 r_v;
   logic [LEN_WIDTH-1:0] r_cnt;
   logic [LEN_WIDTH-1:0] r_len;
   logic                 r_busy;
   logic                 r_in_ready;
   logic                 r_res_valid;
   logic [DW-1:0]        r_res_data;

   logic [DW-1:0]        w_mask;
   logic [DW-1:0]        w_prod;
   logic [DW-1:0]        w_acc_next;
   logic                 w_xfer;
   logic                 w_last;

   // Operand bits at and above OP_BITWIDTH are dropped before capture.
   assign w_mask = {DW{1'b1}} >> (DW - OP_BITWIDTH);

   // Only the low DW bits of the product can reach the wrapped sum,
   // so a DW-wide multiply gives the same result as a full-width one.
   assign w_prod     = r_a * r_b;
   assign w_acc_next = r_v ? (r_acc + w_prod) : r_acc;

   assign w_xfer = in_valid && r_in_ready;
   assign w_last = (r_cnt == r_len - LEN_WIDTH'(1));

   // Job sequencer, operand registers and accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_v         <= 1'b0;
         r_cnt       <= '0;
         r_len       <= '0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_acc <= w_acc_next;
         unique case (r_state)
            S_IDLE: begin
               r_v <= 1'b0;
               if (start) begin
                  r_acc  <= '0;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (len != '0) begin
                     r_len      <= len;
                     r_in_ready <= 1'b1;
                     r_state    <= S_RUN;
                  end else begin
                     r_res_data  <= '0;
                     r_res_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (w_xfer) begin
                  r_a   <= a & w_mask;
                  r_b   <= b & w_mask;
                  r_v   <= 1'b1;
                  r_cnt <= r_cnt + LEN_WIDTH'(1);
                  if (w_last) begin
                     r_in_ready <= 1'b0;
                     r_state    <= S_DRAIN;
                  end
               end else begin
                  r_v <= 1'b0;
               end
            end
            S_DRAIN: begin
               // Last pair lands in the accumulator on this edge.
               r_v         <= 1'b0;
               r_res_data  <= w_acc_next;
               r_res_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               r_v <= 1'b0;
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign in_ready  = r_in_ready;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;

endmodule

// File: tb/tb_conf_int_dot_seq.sv
// tb_conf_int_dot_seq: random and directed jobs on two widths of mask,
// checked against a dot-product model over the queued operand pairs.
module tb_conf_int_dot_seq;

   localparam int DW = 16;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          in_valid;
   logic          res_ready;
   logic [DW-1:0] a;
   logic [DW-1:0] b;

   logic          busy0, in_ready0, res_valid0;
   logic [DW-1:0] res_data0;
   logic          busy1, in_ready1, res_valid1;
   logic [DW-1:0] res_data1;

   int n_chk = 0;
   int n_err = 0;

   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   logic          qv[$];

   always #5 clk = ~clk;

   conf_int_dot_seq #(
      .OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(DW), .LEN_WIDTH(LW)
   ) u_full (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy0),
      .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
      .res_valid(res_valid0), .res_ready(res_ready), .res_data(res_data0)
   );

   conf_int_dot_seq #(
      .OP_BITWIDTH(8), .DATA_PATH_BITWIDTH(DW), .LEN_WIDTH(LW)
   ) u_mask (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy1),
      .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
      .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: sum of masked products, wrapped to DW bits.
   function automatic logic [DW-1:0] dot(input logic [DW-1:0] m);
      int unsigned s = 0;
      for (int i = 0; i < qa.size(); i++)
         s += 32'(qa[i] & m) * 32'(qb[i] & m);
      return s[DW-1:0];
   endfunction

   task automatic add(input logic [DW-1:0] x, input logic [DW-1:0] y);
      qa.push_back(x);
      qb.push_back(y);
   endtask

   task automatic clr();
      qa.delete();
      qb.delete();
      qv.delete();
   endtask

   task automatic run_job(input int hold, input bit poke);
      int            n;
      int            sent;
      int            cyc;
      logic          v;
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
      logic [DW-1:0] d0;
      n  = qa.size();
      e0 = dot(16'hFFFF);
      e1 = dot(16'h00FF);
      @(negedge clk);
      start = 1'b1;
      len   = LW'(n);
      @(negedge clk);
      start = 1'b0;
      chk("busy_start", {busy0, busy1}, 2'b11);
      if (n != 0) begin
         sent = 0;
         cyc  = 0;
         while (sent < n && cyc < 2000) begin
            chk("in_ready_run", {in_ready0, in_ready1}, 2'b11);
            chk("res_valid_run", {res_valid0, res_valid1}, 2'b00);
            v = (qv.size() != 0) ? qv.pop_front()
                                 : ($urandom_range(0, 3) != 0);
            in_valid = v;
            a        = v ? qa[sent] : DW'($urandom);
            b        = v ? qb[sent] : DW'($urandom);
            start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            len      = LW'($urandom);
            @(negedge clk);
            if (v) sent++;
            cyc++;
         end
         if (sent < n) chk("run_timeout", 0, 1);
         in_valid = 1'b0;
         start    = 1'b0;
         chk("in_ready_drain", {in_ready0, in_ready1}, 2'b00);
         chk("res_valid_drain", {res_valid0, res_valid1}, 2'b00);
         @(negedge clk);
      end
      chk("res_valid_done", {res_valid0, res_valid1}, 2'b11);
      chk("in_ready_done", {in_ready0, in_ready1}, 2'b00);
      res_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         chk("res_data_full", res_data0, e0);
         chk("res_data_mask", res_data1, e1);
         chk("res_valid_hold", {res_valid0, res_valid1}, 2'b11);
         start = poke;
         @(negedge clk);
      end
      chk("res_data_full", res_data0, e0);
      chk("res_data_mask", res_data1, e1);
      res_ready = 1'b1;
      start     = poke;
      d0        = res_data0;
      @(negedge clk);
      start     = 1'b0;
      res_ready = 1'b0;
      chk("res_valid_after", {res_valid0, res_valid1}, 2'b00);
      chk("busy_after", {busy0, busy1}, 2'b00);
      chk("res_data_kept", res_data0, d0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      res_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      chk("rst_ctl", {busy0, in_ready0, res_valid0,
                      busy1, in_ready1, res_valid1}, 6'b0);
      chk("rst_data", {res_data0, res_data1}, 32'h0);
      rst = 1'b0;

      // Basic job: 2*3+4*5+6*7 = 68
      clr();
      add(16'd2, 16'd3);
      add(16'd4, 16'd5);
      add(16'd6, 16'd7);
      qv = {1'b1, 1'b1, 1'b1};
      run_job(0, 1'b0);
      chk("basic_68", dot(16'hFFFF), 16'd68);

      // Bubbles and backpressure: 100+1 = 101
      clr();
      add(16'd10, 16'd10);
      add(16'd1, 16'd1);
      qv = {1'b1, 1'b0, 1'b0, 1'b1};
      run_job(5, 1'b1);

      // Wrap: 0xFFFF*0xFFFF + 2 = 3 mod 2^16
      clr();
      add(16'hFFFF, 16'hFFFF);
      add(16'h0002, 16'h0001);
      run_job(1, 1'b0);

      // Masking: 0x23*0x02 = 0x46 on the 8-bit instance
      clr();
      add(16'h0123, 16'h0202);
      run_job(2, 1'b0);

      // Zero length, start poked in DONE
      clr();
      run_job(3, 1'b1);

      // Reset mid-job
      clr();
      @(negedge clk);
      start = 1'b1;
      len   = LW'(4);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      a        = 16'd7;
      b        = 16'd9;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("abort_ctl", {busy0, in_ready0, res_valid0,
                        busy1, in_ready1, res_valid1}, 6'b0);
      chk("abort_data", {res_data0, res_data1}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      add(16'd3, 16'd3);
      run_job(1, 1'b0);

      // Random jobs
      for (int j = 0; j < 25; j++) begin
         clr();
         for (int k = 0; k < $urandom_range(0, 12); k++)
            add(DW'($urandom), DW'($urandom));
         run_job($urandom_range(0, 3), 1'b1);
      end

      // Longest job the counter allows
      clr();
      for (int k = 0; k < 255; k++)
         add(DW'($urandom), DW'($urandom));
      run_job(1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
